mcu_bus_sequencer: RTL

- Parametrised bus-master sequencer for the MCU block. It replaces the tied-off master with a working CSR initiator.
- Commands (write or read of one CSR) are queued in a FIFO and executed in order on the USI CSR bus.
- For reads, it waits for any slave's read-valid, or times out, and returns a response.
- Sits between the MCU command source (UART decoder or boot table) and the USI bus fabric.

---
 rtl/mcu_bus_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mcu_bus_sequencer.sv
// In-order CSR bus-master sequencer for the MCU block: queued write/read commands onto the USI CSR bus.
// Optional build macro MCU_SEQ_WRITE_ACK_EN: writes also return an in-order response on oRsp*.

// Generic circular command FIFO with a registered occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: pushRdy is low while full; a push is then dropped even if a pop happens that cycle.
module mcu_seq_fifo #(
    parameter int pWidth = 8,
    parameter int pDepth = 8
) (
    input  logic                      iSysClk,
    input  logic                      iSysRst,
    input  logic                      pushVld,
    output logic                      pushRdy,
    input  logic [pWidth-1:0]         pushDat,
    output logic                      popVld,
    input  logic                      popRdy,
    output logic [pWidth-1:0]         popDat,
    output logic [$clog2(pDepth):0]   count
);
    localparam int pPtrBit = $clog2(pDepth);
    localparam int pCntBit = pPtrBit + 1;
    localparam logic [pCntBit-1:0] pCntFull = pCntBit'(pDepth);

    logic [pWidth-1:0]  mem [pDepth];
    logic [pPtrBit-1:0] wrPtr;
    logic [pPtrBit-1:0] rdPtr;
    logic               pushFire;
    logic               popFire;

    assign pushRdy  = (count != pCntFull);
    assign popVld   = (count != '0);
    assign pushFire = pushVld && pushRdy;
    assign popFire  = popRdy && popVld;
    assign popDat   = mem[rdPtr];

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushFire) wrPtr <= wrPtr + 1'b1;
            if (popFire)  rdPtr <= rdPtr + 1'b1;
            case ({pushFire, popFire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: flushing the pointers is enough to discard it.
    always_ff @(posedge iSysClk) begin
        if (pushFire) mem[wrPtr] <= pushDat;
    end
endmodule

// Pops queued CSR commands in order and executes them as single-cycle bus strobes.
// Latency: accept at edge k -> strobe in the cycle after k+2; read response in the cycle after valid is sampled.
// Backpressure: oCmdRdy low while the command FIFO is full; responses cannot be stalled.
module mcu_bus_sequencer #(
    parameter int pBusBlockConnect = 1,
    parameter int pBusAdrsBit      = 16,
    parameter int pBusDataBit      = 32,
    parameter int pCmdDepth        = 8,
    parameter int pTimeoutCycles   = 255
) (
    input  logic                        iSysClk,
    input  logic                        iSysRst,
    input  logic [pBusDataBit-1:0]      iCmdWd,
    input  logic [pBusAdrsBit-1:0]      iCmdAdrs,
    input  logic                        iCmdRnW,
    input  logic                        iCmdVd,
    output logic                        oCmdRdy,
    output logic [pBusDataBit-1:0]      oMUsiWd,
    output logic [pBusAdrsBit-1:0]      oMUsiAdrs,
    output logic                        oMUsiWEd,
    output logic                        oMUsiRdReq,
    input  logic [pBusDataBit-1:0]      iMUsiRd,
    input  logic [pBusBlockConnect-1:0] iMUsiREd,
    output logic [pBusDataBit-1:0]      oRspRd,
    output logic                        oRspVd,
    output logic                        oRspErr,
    output logic                        oBusy
);
    localparam int pCntBit     = (pTimeoutCycles > 1) ? $clog2(pTimeoutCycles) : 1;
    localparam int pFifoCntBit = $clog2(pCmdDepth) + 1;
    localparam logic [pCntBit-1:0] pLastCnt = pCntBit'(pTimeoutCycles - 1);

    typedef struct packed {
        logic                   rnW;
        logic [pBusAdrsBit-1:0] adrs;
        logic [pBusDataBit-1:0] wd;
    } cmd_t;

    typedef enum logic [1:0] {sIdle, sIssue, sRwait, sResp} state_t;

    state_t                 state, nextState;
    cmd_t                   pushCmd, headCmd, curCmd, nextCmd;
    logic                   fifoPopVld, fifoPopRdy, pushFire;
    logic [pFifoCntBit-1:0] fifoCount, fifoCntNext;
    logic [pCntBit-1:0]     cnt, nextCnt;
    logic                   wedNext, rdReqNext, rspVdNext, rspErrNext;
    logic [pBusAdrsBit-1:0] adrsNext;
    logic [pBusDataBit-1:0] wdNext, rspRdNext;

    assign pushCmd     = {iCmdRnW, iCmdAdrs, iCmdWd};
    assign pushFire    = iCmdVd && oCmdRdy;
    assign fifoCntNext = fifoCount + pFifoCntBit'(pushFire) - pFifoCntBit'(fifoPopRdy);

    mcu_seq_fifo #(
        .pWidth ($bits(cmd_t)),
        .pDepth (pCmdDepth)
    ) uCmdFifo (
        .iSysClk (iSysClk),
        .iSysRst (iSysRst),
        .pushVld (iCmdVd),
        .pushRdy (oCmdRdy),
        .pushDat (pushCmd),
        .popVld  (fifoPopVld),
        .popRdy  (fifoPopRdy),
        .popDat  (headCmd),
        .count   (fifoCount)
    );

    always_comb begin
        nextState  = state;
        nextCmd    = curCmd;
        nextCnt    = cnt;
        fifoPopRdy = 1'b0;
        wedNext    = 1'b0;
        rdReqNext  = 1'b0;
        adrsNext   = oMUsiAdrs;
        wdNext     = oMUsiWd;
        rspVdNext  = 1'b0;
        rspErrNext = 1'b0;
        rspRdNext  = oRspRd;
        case (state)
            sIdle: begin
                if (fifoPopVld) begin
                    fifoPopRdy = 1'b1;
                    nextCmd    = headCmd;
                    nextState  = sIssue;
                end
            end
            sIssue: begin
                adrsNext = curCmd.adrs;
                if (curCmd.rnW) begin
                    rdReqNext = 1'b1;
                    nextCnt   = '0;
                    nextState = sRwait;
                end else begin
                    wdNext  = curCmd.wd;
                    wedNext = 1'b1;
`ifdef MCU_SEQ_WRITE_ACK_EN
                    nextState = sResp;
`else
                    nextState = sIdle;
`endif
                end
            end
            sRwait: begin
                // A valid in the final count cycle still counts as a real response.
                if (|iMUsiREd) begin
                    rspVdNext = 1'b1;
                    rspRdNext = iMUsiRd;
                    nextState = sResp;
                end else if (cnt == pLastCnt) begin
                    rspVdNext  = 1'b1;
                    rspErrNext = 1'b1;
                    rspRdNext  = '0;
                    nextState  = sResp;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            sResp: begin
                nextState = sIdle;
`ifdef MCU_SEQ_WRITE_ACK_EN
                // Write acks trail the strobe by one cycle; read pulses were raised on entry.
                if (!curCmd.rnW) begin
                    rspVdNext = 1'b1;
                    rspRdNext = curCmd.wd;
                end
`endif
            end
            default: nextState = sIdle;
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state      <= sIdle;
            curCmd     <= '0;
            cnt        <= '0;
            oMUsiWd    <= '0;
            oMUsiAdrs  <= '0;
            oMUsiWEd   <= 1'b0;
            oMUsiRdReq <= 1'b0;
            oRspRd     <= '0;
            oRspVd     <= 1'b0;
            oRspErr    <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            state      <= nextState;
            curCmd     <= nextCmd;
            cnt        <= nextCnt;
            oMUsiWd    <= wdNext;
            oMUsiAdrs  <= adrsNext;
            oMUsiWEd   <= wedNext;
            oMUsiRdReq <= rdReqNext;
            oRspRd     <= rspRdNext;
            oRspVd     <= rspVdNext;
            oRspErr    <= rspErrNext;
            oBusy      <= (fifoCntNext != '0) || (nextState != sIdle);
        end
    end
endmodule
